l1_cache: RTL and testbench
===========================

Name: l1_cache

Overview:
- Direct-mapped, write-back, write-allocate cache directly downstream of the LC-3b core's memory port.
- Receives 16-bit word read/write requests from the core and returns mem_resp/mem_rdata.
- Issues 128-bit line reads and writebacks to physical memory (L2 or main memory) over the pmem_* port.
- Drops in between the core and physical memory; core-side port names match the core's memory signals one-for-one.

Parameters:
- SET_BITS, default 3: log2 of the number of sets (8 sets).
  - Line is fixed at 16 bytes (offset bits [3:0]).
  - Index is addr[4+SET_BITS-1:4]; tag is addr[15:4+SET_BITS] (9 bits at default).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  core read request; held until mem_resp.
- mem_write  in  1  core write request; held until mem_resp.
- mem_byte_enable  in  2  write byte mask: [0] = low byte, [1] = high byte.
- mem_address  in  16  byte address; bit 0 ignored for word selection.
- mem_wdata  in  16  write data.
- mem_resp  out  1  one-cycle completion pulse to the core.
- mem_rdata  out  16  read data, valid while mem_resp=1.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_address  out  16  line address, bits [3:0] always 0.
- pmem_wdata  out  128  victim line data.
- pmem_rdata  in  128  fill data, valid while pmem_resp=1.
- pmem_resp  in  1  physical memory completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all valid and dirty bits clear.
  - mem_resp, pmem_read and pmem_write go to 0; pmem_address goes to 0.
  - Tag and data arrays are not reset.
- State IDLE:
  - A request is active when mem_read|mem_write.
  - hit = valid[idx] && tag[idx]==addr tag.
  - If mem_read and mem_write are both 1, the request is treated as a write.
- Read hit:
  - mem_resp=1 combinationally in the same cycle.
  - mem_rdata = line word addr[3:1].
  - No state change.
- Write hit:
  - mem_resp=1 in the same cycle.
  - On the clock edge, merge mem_wdata into word addr[3:1] per byte enable, and set dirty[idx].
  - byte_enable=2'b00 still responds and still sets dirty.
- Miss, clean or invalid line: go to FILL.
- Miss, valid and dirty line: go to WRITEBACK.
- WRITEBACK:
  - pmem_write=1, pmem_address={old tag, idx, 4'b0}, pmem_wdata=victim line.
  - Hold until pmem_resp, then go to FILL.
- FILL:
  - pmem_read=1, pmem_address={addr tag, idx, 4'b0}.
  - On pmem_resp: write the line, tag and valid=1, clear dirty, return to IDLE.
  - The request then hits on the next cycle.
- Miss latency, clean: 1 (compare) + pmem latency + 1 (hit cycle).
  - Dirty adds one more pmem transaction.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never both 1.
- Core request changes while in WRITEBACK or FILL are illegal; the cache samples the address live, so the core must hold it.
- pmem_resp arriving in IDLE is ignored.
- Reset mid-WRITEBACK or mid-FILL: abort immediately with pmem_* deasserted; the line is left invalid.
- Every index is independent; address wrap 0xFFFF→0x0000 needs no special handling.

Decomposition:
- Add to lc3b_types:
  - lc3b_c_line (128 bits), lc3b_c_tag, lc3b_c_index, lc3b_c_offset
  - state enum {IDLE, WRITEBACK, FILL}
- Sub-module l1_cache_control:
  - Holds the FSM and its outputs: pmem_read/pmem_write, mem_resp, load_line, load_word, set_dirty, clr_dirty, addr_sel.
- l1_cache keeps the arrays, tag compare, word mux and byte merge.

Test Plan:
- Reset, then read 0x0040 → FILL with pmem_address=0x0040; return line word0=0x1234 → next cycle mem_resp=1, mem_rdata=0x1234; no pmem_write.
- Read 0x0042 after the previous test → mem_resp in the same cycle, mem_rdata=line word1, no pmem activity.
- Write 0x0044 data 0xABCD with be=2'b01 onto old word 0x5566 → mem_resp the same cycle; readback=0x55CD; dirty=1.
- Read 0x0C40 (same index, different tag) after the dirty write → WRITEBACK with pmem_address=0x0040 and pmem_wdata word2=0x55CD, then FILL at 0x0C40, then mem_resp.
- Assert rst_n=0 during FILL → pmem_read drops without waiting for a clock; a re-read of the same address misses again.
- mem_read=mem_write=1 on a hit with be=2'b11 → treated as a write; word updated; mem_resp=1 exactly one cycle.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types for the LC-3b L1 cache: line/tag/index/offset types, FSM states and
// the byte-enable merge helper.
package l1_cache_pkg;

    localparam int unsigned LINE_BITS    = 128;
    localparam int unsigned OFFSET_BITS  = 4;
    localparam int unsigned DEF_SET_BITS = 3;

    typedef logic [LINE_BITS-1:0]                        lc3b_c_line;
    typedef logic [OFFSET_BITS-1:0]                      lc3b_c_offset;
    typedef logic [DEF_SET_BITS-1:0]                     lc3b_c_index;
    typedef logic [15-OFFSET_BITS-DEF_SET_BITS:0]        lc3b_c_tag;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} cache_state_e;

    function automatic logic [15:0] merge_word(logic [15:0] old_word, logic [15:0] new_word,
                                               logic [1:0] be);
        merge_word = {be[1] ? new_word[15:8] : old_word[15:8],
                      be[0] ? new_word[7:0]  : old_word[7:0]};
    endfunction

endpackage

// File: rtl/l1_cache_control.sv
// Cache controller FSM: sequences writeback and fill transactions on a miss and
// produces the array load / dirty-bit strobes for the datapath.
module l1_cache_control
    import l1_cache_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit,
    input  logic victim_dirty,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic load_line,
    output logic load_word,
    output logic set_dirty,
    output logic clr_dirty,
    output logic addr_sel
);

    cache_state_e state_q;
    logic         req;
    logic         idle;

    assign req  = mem_read | mem_write;
    assign idle = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        if (victim_dirty) begin
                            state_q    <= WRITEBACK;
                            pmem_write <= 1'b1;
                        end else begin
                            state_q   <= FILL;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_q    <= FILL;
                        pmem_write <= 1'b0;
                        pmem_read  <= 1'b1;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state_q   <= IDLE;
                        pmem_read <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Hits complete combinationally in IDLE; a simultaneous read+write counts as a write.
    assign mem_resp  = idle & req & hit;
    assign load_word = idle & mem_write & hit;
    assign set_dirty = load_word;
    assign load_line = (state_q == FILL) & pmem_resp;
    assign clr_dirty = load_line;
    assign addr_sel  = (state_q == WRITEBACK);

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back, write-allocate L1 cache for the LC-3b core: tag/data arrays,
// tag compare, word mux and byte merge around the l1_cache_control FSM.
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int unsigned SET_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned SETS     = 1 << SET_BITS;
    localparam int unsigned TAG_BITS = 16 - OFFSET_BITS - SET_BITS;

    logic [TAG_BITS-1:0] tag_q [SETS];
    lc3b_c_line          data_q [SETS];
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;

    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [2:0]          word;
    lc3b_c_line          line;
    lc3b_c_line          merged_line;
    logic                hit;
    logic                victim_dirty;
    logic                load_line;
    logic                load_word;
    logic                set_dirty;
    logic                clr_dirty;
    logic                addr_sel;
    logic                unused_addr_bit;

    assign idx             = mem_address[OFFSET_BITS +: SET_BITS];
    assign tag             = mem_address[15 -: TAG_BITS];
    assign word            = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    assign line         = data_q[idx];
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty = valid_q[idx] & dirty_q[idx];

    assign mem_rdata  = line[{word, 4'b0000} +: 16];
    assign pmem_wdata = line;

    // Writeback addresses the victim's stored tag; fill addresses the requested tag.
    assign pmem_address = (pmem_read | pmem_write)
                        ? {(addr_sel ? tag_q[idx] : tag), idx, 4'b0000} : 16'h0000;

    always_comb begin
        merged_line = line;
        merged_line[{word, 4'b0000} +: 16] =
            merge_word(line[{word, 4'b0000} +: 16], mem_wdata, mem_byte_enable);
    end

    always_ff @(posedge clk) begin
        if (load_line) begin
            data_q[idx] <= pmem_rdata;
            tag_q[idx]  <= tag;
        end else if (load_word) begin
            data_q[idx] <= merged_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (load_line) begin
                valid_q[idx] <= 1'b1;
            end
            if (clr_dirty) begin
                dirty_q[idx] <= 1'b0;
            end else if (set_dirty) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    l1_cache_control u_control (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .load_line    (load_line),
        .load_word    (load_word),
        .set_dirty    (set_dirty),
        .clr_dirty    (clr_dirty),
        .addr_sel     (addr_sel)
    );

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios plus random traffic against an
// architectural memory model and a set-level cache occupancy model.
module tb_l1_cache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int total = 0;
    int bad   = 0;

    // pmem: physical memory contents; ref_mem: what the core must observe.
    logic [127:0] pmem    [4096];
    logic [127:0] ref_mem [4096];
    bit   [7:0]   rv;
    bit   [7:0]   rdy;
    logic [8:0]   rt [8];

    always #5 clk = ~clk;

    l1_cache dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    task automatic model_reset();
        rv  = '0;
        rdy = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pmem[i];
    endtask

    // One core transaction with an inline pmem responder; checks latency, pmem traffic and data.
    task automatic access(input bit wr, input bit rd_too, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be,
                          output logic [15:0] rdata, output bit missed,
                          output logic [15:0] wb_addr, output logic [127:0] wb_data);
        int          set_i;
        logic [8:0]  tg;
        bit          exp_hit;
        bit          exp_wb;
        logic [15:0] exp_wb_addr;
        logic [15:0] exp_fill_addr;
        logic [15:0] exp_word;
        logic [127:0] nl;
        int          wb_lat;
        int          fill_lat;
        int          exp_cycles;
        int          wb_seen;
        int          fill_seen;
        int          cyc;
        bit          done;
        set_i         = int'(addr[6:4]);
        tg            = addr[15:7];
        exp_hit       = rv[set_i] && (rt[set_i] == tg);
        exp_wb        = !exp_hit && rv[set_i] && rdy[set_i];
        exp_wb_addr   = {rt[set_i], addr[6:4], 4'b0000};
        exp_fill_addr = {addr[15:4], 4'b0000};
        exp_word      = ref_mem[addr[15:4]][{addr[3:1], 4'b0000} +: 16];
        wb_lat        = $urandom_range(1, 3);
        fill_lat      = $urandom_range(1, 3);
        exp_cycles    = 1 + (exp_hit ? 0 : fill_lat + 1) + (exp_wb ? wb_lat : 0);
        wb_seen = 0; fill_seen = 0; cyc = 0; done = 0;
        rdata = '0; missed = 0; wb_addr = '0; wb_data = '0;

        mem_read        = !wr || rd_too;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (pmem_read && pmem_write) begin
                bad++;
                $display("FAIL pmem_exclusive: got read=1 write=1 want at most one");
            end
            if (mem_resp) begin
                done = 1;
                total++;
                if (cyc !== exp_cycles) begin
                    bad++;
                    $display("FAIL latency @%h: got %0d cycles want %0d", addr, cyc, exp_cycles);
                end
                total++;
                if ((wb_seen > 0) !== exp_wb || (fill_seen > 0) !== !exp_hit) begin
                    bad++;
                    $display("FAIL miss_path @%h: got wb=%0d fill=%0d want wb=%0d fill=%0d",
                             addr, wb_seen > 0, fill_seen > 0, exp_wb, !exp_hit);
                end
                rdata = mem_rdata;
                if (!wr) begin
                    total++;
                    if (mem_rdata !== exp_word) begin
                        bad++;
                        $display("FAIL rdata @%h: got %h want %h", addr, mem_rdata, exp_word);
                    end
                end
            end else if (pmem_write) begin
                wb_seen++;
                if (wb_seen == 1) begin
                    wb_addr = pmem_address;
                    wb_data = pmem_wdata;
                    total++;
                    if (pmem_address !== exp_wb_addr ||
                        pmem_wdata !== ref_mem[exp_wb_addr[15:4]]) begin
                        bad++;
                        $display("FAIL wb_line: got %h/%h want %h/%h", pmem_address, pmem_wdata,
                                 exp_wb_addr, ref_mem[exp_wb_addr[15:4]]);
                    end
                end
                if (wb_seen == wb_lat) begin
                    pmem[pmem_address[15:4]] = pmem_wdata;
                    pmem_resp = 1'b1;
                end
            end else if (pmem_read) begin
                fill_seen++;
                missed = 1;
                if (fill_seen == 1) begin
                    total++;
                    if (pmem_address !== exp_fill_addr) begin
                        bad++;
                        $display("FAIL fill_addr: got %h want %h", pmem_address, exp_fill_addr);
                    end
                end
                if (fill_seen == fill_lat) begin
                    pmem_rdata = pmem[pmem_address[15:4]];
                    pmem_resp  = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout @%h: got no mem_resp want mem_resp within 60 cycles", addr);
        end else begin
            @(negedge clk);
            total++;
            if (mem_resp !== 1'b0) begin
                bad++;
                $display("FAIL resp_pulse @%h: got %b want 0", addr, mem_resp);
            end
            @(posedge clk);
            #1;
            if (!exp_hit) rdy[set_i] = 0;
            rv[set_i] = 1;
            rt[set_i] = tg;
            if (wr) begin
                nl = ref_mem[addr[15:4]];
                if (be[0]) nl[{addr[3:1], 4'b0000} +: 8] = wd[7:0];
                if (be[1]) nl[{addr[3:1], 4'b1000} +: 8] = wd[15:8];
                ref_mem[addr[15:4]] = nl;
                rdy[set_i] = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 ||
            pmem_address !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h want 0 0 0 0000",
                     mem_resp, pmem_read, pmem_write, pmem_address);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt;
        access(0, 0, 16'h0040, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (rd !== 16'h1234 || ms !== 1'b1) begin
            bad++;
            $display("FAIL fill_read: got %h miss=%b want 1234 miss=1", rd, ms);
        end
    endtask

    task automatic test_read_hit();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt;
        access(0, 0, 16'h0042, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (ms !== 1'b0) begin
            bad++;
            $display("FAIL read_hit: got miss=%b want 0", ms);
        end
    endtask

    task automatic test_write_hit();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt;
        access(1, 0, 16'h0044, 16'hABCD, 2'b01, rd, ms, wa, wdt);
        access(0, 0, 16'h0044, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (rd !== 16'h55CD) begin
            bad++;
            $display("FAIL byte_merge: got %h want 55cd", rd);
        end
    endtask

    task automatic test_writeback();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt;
        access(0, 0, 16'h0C40, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (wa !== 16'h0040 || wdt[47:32] !== 16'h55CD) begin
            bad++;
            $display("FAIL writeback: got %h word2=%h want 0040 word2=55cd", wa, wdt[47:32]);
        end
    endtask

    task automatic test_rw_both();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt; logic [15:0] v;
        v = 16'($urandom);
        access(1, 1, 16'h0C46, v, 2'b11, rd, ms, wa, wdt);
        access(0, 0, 16'h0C46, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (rd !== v) begin
            bad++;
            $display("FAIL rw_both: got %h want %h", rd, v);
        end
    endtask

    task automatic test_stray_resp();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt;
        @(negedge clk);
        pmem_rdata = {4{32'($urandom)}};
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        access(0, 0, 16'h0C42, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (ms !== 1'b0) begin
            bad++;
            $display("FAIL stray_resp: got miss=%b want 0", ms);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt; bit seen;
        seen = 0;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_address = 16'h1230;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (!seen || pmem_read !== 1'b0 || pmem_address !== 16'h0000) begin
            bad++;
            $display("FAIL reset_abort: got seen=%b rd=%b addr=%h want 1 0 0000",
                     seen, pmem_read, pmem_address);
        end
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        access(0, 0, 16'h1230, 16'h0, 2'b00, rd, ms, wa, wdt);
        total++;
        if (ms !== 1'b1) begin
            bad++;
            $display("FAIL reread_after_reset: got miss=%b want 1", ms);
        end
    endtask

    task automatic test_random();
        logic [15:0] rd; bit ms; logic [15:0] wa; logic [127:0] wdt;
        logic [15:0] a; logic [8:0] tg; bit wr; bit both;
        for (int n = 0; n < 200; n++) begin
            tg   = ($urandom_range(0, 4) == 4) ? 9'h1FF : 9'($urandom_range(0, 3));
            a    = {tg, 3'($urandom), 3'($urandom), 1'($urandom)};
            wr   = 1'($urandom);
            both = wr && ($urandom_range(0, 5) == 0);
            access(wr, both, a, 16'($urandom), 2'($urandom), rd, ms, wa, wdt);
        end
    endtask

    initial begin
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        mem_address = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        for (int i = 0; i < 4096; i++) pmem[i] = {32'($urandom), 32'($urandom),
                                                  32'($urandom), 32'($urandom)};
        pmem[4][15:0]  = 16'h1234;
        pmem[4][47:32] = 16'h5566;
        for (int i = 0; i < 8; i++) rt[i] = '0;
        test_reset();
        test_fill();
        test_read_hit();
        test_write_hit();
        test_writeback();
        test_rw_both();
        test_stray_resp();
        test_reset_mid_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
